// File: rtl/data_memory_responder.sv
// Fixed-latency line memory that answers cache-controller read/write requests.
// Array contents are never reset so a bench or loader can preload them.
module data_memory_responder #(
    parameter int LATENCY = 10,
    parameter int LINES   = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
);

    localparam int IDX_W = $clog2(LINES);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [7:0] LAST   = 8'(LATENCY - 1);

    logic [0:0]       state;
    logic [7:0]       count;
    logic             lat_write;
    logic [IDX_W-1:0] lat_idx;
    logic [255:0]     lat_data;

    logic [255:0] mem [LINES];

    logic unused_addr;
    assign unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            count  <= '0;
            ack_o  <= 1'b0;
            data_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ack_o <= 1'b0;
                    if (enable_i) begin
                        state     <= S_WAIT;
                        count     <= '0;
                        lat_write <= write_i;
                        lat_idx   <= addr_i[IDX_W+4:5];
                        lat_data  <= data_i;
                    end
                end
                default: begin
                    // The ack cycle always completes, even if enable_i drops in it.
                    if (ack_o) begin
                        ack_o <= 1'b0;
                        state <= S_IDLE;
                    end else if (!enable_i) begin
                        state <= S_IDLE;
                    end else begin
                        count <= count + 8'd1;
                        if (count == LAST) begin
                            ack_o <= 1'b1;
                            if (!lat_write)
                                data_o <= mem[lat_idx];
                        end
                    end
                end
            endcase
        end
    end

    // Writes commit at the edge closing the ack cycle, so reset there cancels them.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == S_WAIT && ack_o && lat_write)
            mem[lat_idx] <= lat_data;
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: latency, aliasing, back-to-back,
// abort and reset behaviour with hand-computed expectations.
module tb_data_memory_responder;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         write;
    logic [31:0]  addr;
    logic [255:0] din;
    logic         ack;
    logic [255:0] dout;

    int vecs = 0;
    int errs = 0;

    localparam logic [255:0] L3  = {32{8'hA5}};
    localparam logic [255:0] L5  = {8{32'h5555_0005}};
    localparam logic [255:0] L7O = {8{32'h7777_0000}};
    localparam logic [255:0] L7N = {8{32'hC0DE_0007}};
    localparam logic [255:0] L9  = {8{32'h9999_1009}};

    data_memory_responder #(.LATENCY(LAT), .LINES(512)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .write_i(write),
        .addr_i(addr), .data_i(din), .ack_o(ack), .data_o(dout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, scramble inputs after acceptance, drop enable at ack.
    task automatic run_txn(input logic wr, input logic [31:0] a, input logic [255:0] d,
                           output int ack_at, output int nacks,
                           output logic [255:0] d_ack, output logic [255:0] d_after);
        ack_at = -1; nacks = 0; d_ack = '0; d_after = '0;
        write = wr; addr = a; din = d; enable = 1'b1;
        tick();
        write = ~wr; addr = a ^ 32'h0000_3FE0; din = ~d;
        for (int k = 1; k <= LAT + 4; k++) begin
            tick();
            if (ack) begin
                nacks++; ack_at = k; d_ack = dout; enable = 1'b0;
            end
            if (ack_at > 0 && k == ack_at + 1) d_after = dout;
        end
        enable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; write = 1'b0; addr = '0; din = '0;
        tick(); tick();
        vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL reset_ack got %b want 0", ack); end
        vecs++; if (dout !== '0) begin errs++; $display("FAIL reset_data got %h want 0", dout); end
        rst = 1'b0;
        tick();
        vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL idle_ack got %b want 0", ack); end
    endtask

    task automatic test_read_latency();
        int bad = 0;
        write = 1'b0; addr = 32'h60; din = '0; enable = 1'b1;
        tick();
        addr = 32'h1E0; write = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (ack !== (k == LAT)) begin
                bad++; $display("FAIL read_ack cycle %0d got %b want %b", k, ack, k == LAT);
            end
            if (k == LAT) begin
                enable = 1'b0;
                vecs++; if (dout !== L3) begin errs++; $display("FAIL read_data_ack got %h want %h", dout, L3); end
            end
            if (k == LAT + 1) begin
                vecs++; if (dout !== L3) begin errs++; $display("FAIL read_data_hold got %h want %h", dout, L3); end
            end
        end
        write = 1'b0;
        vecs++; if (bad != 0) errs++;
    endtask

    task automatic test_write_read_alias();
        int at, n; logic [255:0] da, db;
        run_txn(1'b1, 32'h0000_4020, 256'h1234, at, n, da, db);
        vecs++; if (at != LAT || n != 1) begin errs++; $display("FAIL write_ack at %0d n %0d want %0d/1", at, n, LAT); end
        vecs++; if (da !== L3) begin errs++; $display("FAIL write_keeps_data got %h want %h", da, L3); end
        run_txn(1'b0, 32'hFFFF_C03F, '0, at, n, da, db);
        vecs++; if (at != LAT || da !== 256'h1234) begin errs++; $display("FAIL alias_read at %0d got %h want 1234", at, da); end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1, n = 0;
        logic [255:0] d2 = '0;
        int at, m; logic [255:0] da, db;
        write = 1'b1; addr = 32'hE0; din = L7N; enable = 1'b1;
        tick();
        for (int k = 1; k <= 2 * LAT + 6; k++) begin
            tick();
            if (ack) begin
                n++;
                if (first < 0) first = k; else begin second = k; d2 = dout; enable = 1'b0; end
            end
            if (k == LAT + 1) begin write = 1'b0; addr = 32'h120; din = '0; end
        end
        enable = 1'b0;
        // Eleven quiet cycles sit between the two pulses.
        vecs++; if (n != 2 || first != LAT || second != 2 * LAT + 2) begin
            errs++; $display("FAIL b2b_acks n %0d at %0d,%0d want 2 at %0d,%0d", n, first, second, LAT, 2 * LAT + 2);
        end
        vecs++; if (d2 !== L9) begin errs++; $display("FAIL b2b_refill got %h want %h", d2, L9); end
        run_txn(1'b0, 32'hE0, '0, at, m, da, db);
        vecs++; if (da !== L7N) begin errs++; $display("FAIL b2b_writeback got %h want %h", da, L7N); end
    endtask

    task automatic test_abort();
        int n = 0;
        int at, m; logic [255:0] da, db;
        write = 1'b0; addr = 32'h60; enable = 1'b1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ack) n++;
            if (k == 3) enable = 1'b0;
        end
        vecs++; if (n != 0) begin errs++; $display("FAIL abort_read acks %0d want 0", n); end
        vecs++; if (dout !== L7N) begin errs++; $display("FAIL abort_data got %h want %h", dout, L7N); end
        write = 1'b1; addr = 32'h60; din = '1; enable = 1'b1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ack) n++;
            if (k == 6) enable = 1'b0;
        end
        vecs++; if (n != 0) begin errs++; $display("FAIL abort_write acks %0d want 0", n); end
        run_txn(1'b0, 32'h60, '0, at, m, da, db);
        vecs++; if (da !== L3) begin errs++; $display("FAIL abort_nowrite got %h want %h", da, L3); end
    endtask

    task automatic test_spurious();
        int n = 0;
        int at, m; logic [255:0] da, db;
        write = 1'b0; addr = 32'hA0; enable = 1'b1;
        tick();
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (ack) n++;
            if (k == LAT + 2) enable = 1'b0;
        end
        vecs++; if (n != 1) begin errs++; $display("FAIL spurious_acks got %0d want 1", n); end
        vecs++; if (dout !== L5) begin errs++; $display("FAIL spurious_data got %h want %h", dout, L5); end
        run_txn(1'b0, 32'h60, '0, at, m, da, db);
        vecs++; if (at != LAT || m != 1 || da !== L3) begin
            errs++; $display("FAIL spurious_next at %0d n %0d got %h want %0d/1/%h", at, m, da, LAT, L3);
        end
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        int at, m; logic [255:0] da, db;
        write = 1'b1; addr = 32'hE0; din = '1; enable = 1'b1;
        tick();
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (ack) n++;
            if (k == 4) rst = 1'b1;
            if (k == 5) begin rst = 1'b0; enable = 1'b0; end
        end
        vecs++; if (n != 0) begin errs++; $display("FAIL rst_mid acks %0d want 0", n); end
        vecs++; if (dout !== '0) begin errs++; $display("FAIL rst_mid data got %h want 0", dout); end
        write = 1'b1; addr = 32'hE0; din = '1; enable = 1'b1;
        tick();
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == LAT) begin rst = 1'b1; enable = 1'b0; end
            if (k == LAT + 1) rst = 1'b0;
        end
        run_txn(1'b0, 32'hE0, '0, at, m, da, db);
        vecs++; if (at != LAT || da !== L7N) begin
            errs++; $display("FAIL rst_ack_cycle at %0d got %h want %0d/%h", at, da, LAT, L7N);
        end
    endtask

    initial begin
        dut.mem[3] = L3;
        dut.mem[5] = L5;
        dut.mem[7] = L7O;
        dut.mem[9] = L9;
        test_reset();
        test_read_latency();
        test_write_read_alias();
        test_back_to_back();
        test_abort();
        test_spurious();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
